// File: rtl/pid_ctrl_pipe.sv
// Three-stage pipelined PID heading controller: saturate error, form P/I/D terms,
// then mix the correction into forward speed for left/right motor commands.
module pid_ctrl_pipe #(
  parameter int unsigned ERR_W     = 12,
  parameter int unsigned SAT_W     = 10,
  parameter int unsigned FRWRD_W   = 10,
  parameter int unsigned P_COEFF   = 16,
  parameter int unsigned D_COEFF   = 7,
  parameter int unsigned D_SAT_W   = 8,
  parameter int unsigned D_DEPTH   = 4,
  parameter int unsigned INTG_W    = 15,
  parameter int unsigned I_SHIFT   = 6,
  parameter int unsigned PID_W     = 14,
  parameter int unsigned OUT_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      moving,
  input  logic                      err_vld,
  input  logic                      intg_clr,
  input  logic signed [ERR_W-1:0]   error,
  input  logic        [FRWRD_W-1:0] frwrd,
  output logic signed [FRWRD_W:0]   lft_spd,
  output logic signed [FRWRD_W:0]   rght_spd,
  output logic                      spd_vld,
  output logic signed [INTG_W-1:0]  integ
);

  localparam int unsigned DW = SAT_W + 1;
  localparam int unsigned SW = ((PID_W > FRWRD_W + 1) ? PID_W : FRWRD_W + 1) + 1;

  localparam logic signed [ERR_W-1:0] ErrHi = ERR_W'(2 ** (SAT_W - 1) - 1);
  localparam logic signed [ERR_W-1:0] ErrLo = ERR_W'(-(2 ** (SAT_W - 1)));
  localparam logic signed [DW-1:0]    DHi   = DW'(2 ** (D_SAT_W - 1) - 1);
  localparam logic signed [DW-1:0]    DLo   = DW'(-(2 ** (D_SAT_W - 1)));
  localparam logic signed [SW-1:0]    SHi   = SW'(2 ** FRWRD_W - 1);
  localparam logic signed [SW-1:0]    SLo   = SW'(-(2 ** FRWRD_W - 1));
  localparam logic signed [PID_W-1:0] PCoef = PID_W'(P_COEFF);
  localparam logic signed [PID_W-1:0] DCoef = PID_W'(D_COEFF);

  // E1 state
  logic signed [SAT_W-1:0]   err_sat_q, err_sat_d;
  logic        [FRWRD_W-1:0] frwrd1_q, frwrd1_d;
  logic                      v1_q, v1_d;
  // E2 state
  logic signed [PID_W-1:0]   p_q, p_d, d_q, d_d, i_q, i_d;
  logic        [FRWRD_W-1:0] frwrd2_q, frwrd2_d;
  logic                      v2_q, v2_d;
  logic signed [INTG_W-1:0]  integ_q, integ_d;
  logic signed [SAT_W-1:0]   hist_q [D_DEPTH];
  logic signed [SAT_W-1:0]   hist_d [D_DEPTH];
  // E3 state
  logic signed [FRWRD_W:0]   lft_q, lft_d, rght_q, rght_d;
  logic                      vld_q, vld_d;

  logic signed [DW-1:0]      diff;
  logic signed [D_SAT_W-1:0] d_sat;
  logic signed [INTG_W-1:0]  intg_sum;
  logic                      intg_ovf;
  logic signed [PID_W-1:0]   p_prod, pid, corr;
  logic signed [SW-1:0]      fw, corr_x, lsum, rsum;

  always_comb begin
    v1_d      = moving & err_vld;
    err_sat_d = err_sat_q;
    frwrd1_d  = frwrd1_q;
    if (v1_d) begin
      if (error > ErrHi)      err_sat_d = ErrHi[SAT_W-1:0];
      else if (error < ErrLo) err_sat_d = ErrLo[SAT_W-1:0];
      else                    err_sat_d = error[SAT_W-1:0];
      frwrd1_d = frwrd;
    end
  end

  always_comb begin
    diff = DW'(err_sat_q) - DW'(hist_q[D_DEPTH-1]);
    if (diff > DHi)      d_sat = DHi[D_SAT_W-1:0];
    else if (diff < DLo) d_sat = DLo[D_SAT_W-1:0];
    else                 d_sat = diff[D_SAT_W-1:0];

    intg_sum = integ_q + INTG_W'(err_sat_q);
    // Overflow only possible when both operands share a sign and the sum flips it
    intg_ovf = (integ_q[INTG_W-1] == err_sat_q[SAT_W-1]) &&
               (intg_sum[INTG_W-1] != integ_q[INTG_W-1]);
    p_prod   = PID_W'(err_sat_q) * PCoef;

    p_d      = p_q;
    d_d      = d_q;
    i_d      = i_q;
    frwrd2_d = frwrd2_q;
    hist_d   = hist_q;
    integ_d  = integ_q;
    v2_d     = moving & v1_q;

    if (v1_q) begin
      p_d      = p_prod >>> 1;
      d_d      = PID_W'(d_sat) * DCoef;
      frwrd2_d = frwrd1_q;
      for (int k = D_DEPTH - 1; k > 0; k--) hist_d[k] = hist_q[k-1];
      hist_d[0] = err_sat_q;
      if (!intg_ovf) integ_d = intg_sum;
    end
    if (intg_clr) integ_d = '0;
    if (!moving) begin
      integ_d = '0;
      hist_d  = '{default: '0};
    end
    if (v1_q) i_d = PID_W'(integ_d >>> I_SHIFT);
  end

  always_comb begin
    pid    = p_q + i_q + d_q;
    corr   = pid >>> OUT_SHIFT;
    fw     = SW'(frwrd2_q);
    corr_x = SW'(corr);
    lsum   = fw + corr_x;
    rsum   = fw - corr_x;
    lft_d  = lft_q;
    rght_d = rght_q;
    vld_d  = moving & v2_q;
    if (v2_q) begin
      if (lsum > SHi)      lft_d = SHi[FRWRD_W:0];
      else if (lsum < SLo) lft_d = SLo[FRWRD_W:0];
      else                 lft_d = lsum[FRWRD_W:0];
      if (rsum > SHi)      rght_d = SHi[FRWRD_W:0];
      else if (rsum < SLo) rght_d = SLo[FRWRD_W:0];
      else                 rght_d = rsum[FRWRD_W:0];
    end
    if (!moving) begin
      lft_d  = '0;
      rght_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sat_q <= '0;
      frwrd1_q  <= '0;
      v1_q      <= 1'b0;
      p_q       <= '0;
      d_q       <= '0;
      i_q       <= '0;
      frwrd2_q  <= '0;
      v2_q      <= 1'b0;
      integ_q   <= '0;
      hist_q    <= '{default: '0};
      lft_q     <= '0;
      rght_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      err_sat_q <= err_sat_d;
      frwrd1_q  <= frwrd1_d;
      v1_q      <= v1_d;
      p_q       <= p_d;
      d_q       <= d_d;
      i_q       <= i_d;
      frwrd2_q  <= frwrd2_d;
      v2_q      <= v2_d;
      integ_q   <= integ_d;
      hist_q    <= hist_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
      vld_q     <= vld_d;
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign spd_vld  = vld_q;
  assign integ    = integ_q;

endmodule

// File: tb/tb_pid_ctrl_pipe.sv
// Bench for pid_ctrl_pipe: directed scenarios plus random traffic, all checked against
// an integer-arithmetic sample-by-sample model of the controller.
module tb_pid_ctrl_pipe;

  logic               clk = 1'b0;
  logic               rst_n, moving, err_vld, intg_clr;
  logic signed [11:0] error;
  logic        [9:0]  frwrd;
  logic signed [10:0] lft_spd, rght_spd;
  logic               spd_vld;
  logic signed [14:0] integ;

  always #5 clk = ~clk;

  pid_ctrl_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .moving   (moving),
    .err_vld  (err_vld),
    .intg_clr (intg_clr),
    .error    (error),
    .frwrd    (frwrd),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .spd_vld  (spd_vld),
    .integ    (integ)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: each accepted sample is turned into its final speeds when it
  // reaches the integrator step, then released on its due edge.
  typedef struct {int esat; int fw; int due;} samp_t;
  typedef struct {int l; int r; int due;} out_t;
  samp_t inq[$];
  out_t  outq[$];
  int    m_integ, m_lft, m_rght, m_vld, edge_n;
  int    m_hist[4];

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_clear();
    m_integ = 0;
    m_lft   = 0;
    m_rght  = 0;
    m_vld   = 0;
    for (int k = 0; k < 4; k++) m_hist[k] = 0;
    inq.delete();
    outq.delete();
  endtask

  task automatic model_step();
    samp_t s;
    int p, d, i, sum, pid, corr;
    if (!moving) begin
      model_clear();
    end else begin
      m_vld = 0;
      if (outq.size() > 0 && outq[0].due == edge_n) begin
        m_lft  = outq[0].l;
        m_rght = outq[0].r;
        m_vld  = 1;
        void'(outq.pop_front());
      end
      if (inq.size() > 0 && inq[0].due == edge_n) begin
        s = inq.pop_front();
        p = (s.esat * 16) >>> 1;
        d = clampi(s.esat - m_hist[3], -128, 127) * 7;
        for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = s.esat;
        sum = m_integ + s.esat;
        if (sum >= -16384 && sum <= 16383) m_integ = sum;
        if (intg_clr) m_integ = 0;
        i    = m_integ >>> 6;
        pid  = p + i + d;
        corr = pid >>> 3;
        outq.push_back('{l: clampi(s.fw + corr, -1023, 1023),
                         r: clampi(s.fw - corr, -1023, 1023), due: edge_n + 1});
      end else if (intg_clr) begin
        m_integ = 0;
      end
      if (err_vld)
        inq.push_back('{esat: clampi(int'(error), -512, 511), fw: int'(frwrd), due: edge_n + 1});
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    edge_n++;
    #1;
    check_val("spd_vld", int'(spd_vld), m_vld);
    check_val("lft_spd", lft_spd, m_lft);
    check_val("rght_spd", rght_spd, m_rght);
    check_val("integ", integ, m_integ);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; moving = 1'b0; err_vld = 1'b0; intg_clr = 1'b0;
    error = '0; frwrd = '0; edge_n = 0;
    model_clear();
    #12;
    check_val("rst_spd_vld", int'(spd_vld), 0);
    check_val("rst_lft", lft_spd, 0);
    check_val("rst_rght", rght_spd, 0);
    check_val("rst_integ", integ, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero error: speeds equal forward, strobe on the third cycle
    moving = 1'b1; frwrd = 10'd512; error = '0; err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    check_val("t2_early_vld", int'(spd_vld), 0);
    tick();
    check_val("t2_vld", int'(spd_vld), 1);
    check_val("t2_lft", lft_spd, 512);
    check_val("t2_rght", rght_spd, 512);

    // Max positive error from reset
    do_reset();
    error = 12'h7FF; err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    tick();
    check_val("t3_lft", lft_spd, 1023);
    check_val("t3_rght", rght_spd, -111);
    check_val("t3_integ", integ, 511);

    // Anti-windup
    do_reset();
    error = 12'sd511; err_vld = 1'b1;
    for (int n = 0; n < 33; n++) tick();
    check_val("t4_integ32", integ, 16352);
    for (int n = 0; n < 7; n++) tick();
    err_vld = 1'b0;
    tick();
    check_val("t4_integ_hold", integ, 16352);

    // Drop moving right after a sample: nothing escapes
    error = 12'sd100; err_vld = 1'b1;
    tick();
    err_vld = 1'b0; moving = 1'b0;
    tick();
    moving = 1'b1;
    tick();
    tick();
    check_val("t5_vld", int'(spd_vld), 0);
    check_val("t5_lft", lft_spd, 0);
    check_val("t5_rght", rght_spd, 0);
    check_val("t5_integ", integ, 0);

    // Step error for derivative history, with a clear pulse mid-run
    frwrd = 10'd300; error = '0; err_vld = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    error = 12'sd100;
    for (int n = 0; n < 6; n++) tick();
    intg_clr = 1'b1;
    tick();
    check_val("t6_clr", integ, 0);
    intg_clr = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    err_vld = 1'b0;
    for (int n = 0; n < 3; n++) tick();

    // Reset asserted mid-stream
    err_vld = 1'b1; error = 12'sd250; frwrd = 10'd700;
    for (int n = 0; n < 5; n++) tick();
    rst_n = 1'b0;
    #1;
    check_val("t1_vld", int'(spd_vld), 0);
    check_val("t1_lft", lft_spd, 0);
    check_val("t1_rght", rght_spd, 0);
    check_val("t1_integ", integ, 0);
    model_clear();
    err_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    check_val("t1_no_vld", int'(spd_vld), 0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      moving   = ($urandom_range(99) >= 3);
      err_vld  = ($urandom_range(9) < 7);
      intg_clr = ($urandom_range(29) == 0);
      if ($urandom_range(3) == 0) error = 12'($urandom);
      else                        error = 12'($urandom_range(1200) - 600);
      frwrd = 10'($urandom);
      tick();
    end
    moving = 1'b1; err_vld = 1'b0; intg_clr = 1'b0;
    for (int n = 0; n < 4; n++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
